pbit_spi_bridge: RTL
====================

Name: pbit_spi_bridge

Overview:
Parametrised successor to the p-bit wrapper. It generates the slow analog sampling clock and captures p-bit samples into a live register. It also decodes an opcode-framed SPI stream that supports burst weight writes, burst weight read-back and coherent p-bit snapshot streaming. The block sits between the analog p-bit array and the external SPI host. It also serves the weight SRAM to the analog array through a registered read port.

Parameters:
NUM_PBIT, 4700, number of p-bits and weight words
ADDR_WIDTH, 13, address width; must satisfy 2^ADDR_WIDTH >= NUM_PBIT
DATA_WIDTH, 8, weight word width
DIV_HALF, 32, clk cycles per clk_analog half-period; must be even and at least 2

Ports:
clk  in  1  the block's single clock (also the SPI bit clock)
rstn  in  1  reset, synchronous, active-low
bit_flips  in  NUM_PBIT  p-bit values from the analog array
clk_analog  out  1  p-bit sampling clock
cs_n  in  1  SPI chip select, active-low
MOSI  in  1  SPI data in, sampled on posedge clk while cs_n=0
MISO  out  1  SPI data out, registered
wt_addr  in  ADDR_WIDTH  analog-side weight read address
wt_data  out  DATA_WIDTH  weight at wt_addr, 1-cycle latency
err  out  1  sticky out-of-range or bad-frame flag, cleared by reset

Behaviour:
- Reset (rstn=0 at posedge clk) clears: clk_analog=0, MISO=0, wt_data=0, err=0, divider counter, FSM (state IDLE), live register, snapshot register. Weight SRAM contents are not reset.
- Divider: clk_analog toggles every DIV_HALF clks. The first rise occurs DIV_HALF clks after reset release.
- Live capture: live_pbits <= bit_flips on the clk edge where clk_analog falls, i.e. mid-period after the rise.
- Frame format, MSB-first: 2-bit opcode, then ADDR_WIDTH-bit start address, then payload.
- Opcodes: 00 NOP, 01 WRITE, 10 READ_WT, 11 READ_PB.
- FSM states: IDLE, OPCODE, ADDR, WR_DATA, RD_WT, RD_PB, DRAIN.
- IDLE -> OPCODE on the first clk with cs_n=0; that bit is sampled as opcode MSB.
- After 2 opcode bits: ADDR.
- After ADDR_WIDTH address bits:
  - start address >= NUM_PBIT (any non-NOP opcode): set err, go to DRAIN.
  - otherwise go to WR_DATA, RD_WT or RD_PB according to the opcode; NOP goes to DRAIN.
- WRITE: each DATA_WIDTH bits forms one word. The SRAM write occurs on the edge sampling the word's last bit. The address then increments and wraps from NUM_PBIT-1 to 0.
- READ_WT: the word at the current address is loaded into an out-shift register on the edge sampling the last address bit. MISO presents its MSB from that edge onward, one bit per clk. The next word (address incremented, wrapping) is loaded seamlessly after each DATA_WIDTH bits.
- READ_PB: snapshot <= live_pbits on the edge sampling the last address bit. The snapshot is frozen for the rest of the frame. MISO streams snapshot[addr], snapshot[addr+1], and so on, one bit per clk, wrapping NUM_PBIT-1 -> 0. Live captures continue but do not affect the open frame.
- DRAIN: ignore MOSI, MISO=0 until cs_n rises.
- cs_n=1 at any clk forces IDLE and MISO=0 on that edge.
  - A partial WRITE word is discarded, with no SRAM write.
  - A completed word already written stays written.
- MISO=0 in every state other than RD_WT and RD_PB.
- Simultaneous SRAM write and wt_addr read at the same address returns the old data (read-before-write).

Decomposition:
- Package pbit_pkg: opcode enum (2 bits), FSM state enum, and opcode width constant OP_W=2.
- Sub-module pbit_clk_div: divider, clk_analog and a 1-cycle capture pulse on the fall. Parameter DIV_HALF.

Test Plan:
- Reset then 200 idle clks with DIV_HALF=4 -> clk_analog toggles every 4 clks starting at clk 4; live_pbits loads on each falling edge.
- WRITE frame: addr=5, payload 0xA5,0x3C; cs_n high -> SRAM[5]=0xA5, SRAM[6]=0x3C; wt_addr=6 gives wt_data=0x3C one clk later; err=0.
- READ_WT frame: addr=5, 16 clks -> MISO bits = 1010_0101_0011_1100, starting the clk after the last address bit.
- READ_PB frame: addr=NUM_PBIT-2, stream 4 bits, bit_flips changes mid-frame -> MISO = snapshot[NUM_PBIT-2], snapshot[NUM_PBIT-1], snapshot[0], snapshot[1], all from the pre-change snapshot.
- WRITE frame: addr=NUM_PBIT -> err=1, MISO=0, no SRAM change. Then WRITE with cs_n rising after 3 data bits -> target word unchanged; next frame decodes normally.
- rstn=0 mid-READ_WT -> MISO=0, FSM IDLE, err=0 next edge; SRAM contents preserved (verified by a READ_WT afterwards).

Source files
------------

// File: rtl/pbit_pkg.sv
// Shared types for the p-bit SPI bridge: SPI opcodes and the frame decoder states.
package pbit_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ_WT = 2'b10,
    OP_READ_PB = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_WT,
    ST_RD_PB,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/pbit_clk_div.sv
// Divides clk into the analog sampling clock and flags the clk edge on which
// clk_analog falls so the live p-bit register can capture mid-period.
module pbit_clk_div #(
  parameter int DIV_HALF = 32
) (
  input  logic clk,
  input  logic rstn,
  output logic clk_analog,
  output logic fall_pulse
);

  localparam int CW = $clog2(DIV_HALF);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_analog_q, clk_analog_d;
  logic          wrap;

  always_comb begin
    wrap         = (cnt_q == CW'(DIV_HALF - 1));
    cnt_d        = wrap ? '0 : cnt_q + CW'(1);
    clk_analog_d = wrap ? ~clk_analog_q : clk_analog_q;
    // Combinational so the capture lands on the same edge that drops clk_analog.
    fall_pulse   = wrap && clk_analog_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q        <= '0;
      clk_analog_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clk_analog_q <= clk_analog_d;
    end
  end

  assign clk_analog = clk_analog_q;

endmodule

// File: rtl/pbit_spi_bridge.sv
// Bridge between the analog p-bit array and an SPI host: sampling clock, live
// p-bit capture, opcode-framed SPI decoder and the weight SRAM with its analog read port.
module pbit_spi_bridge
  import pbit_pkg::*;
#(
  parameter int NUM_PBIT   = 4700,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_HALF   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_PBIT-1:0]   bit_flips,
  output logic                  clk_analog,
  input  logic                  cs_n,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [ADDR_WIDTH-1:0] wt_addr,
  output logic [DATA_WIDTH-1:0] wt_data,
  output logic                  err
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PBIT - 1);

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < 32'(NUM_PBIT));
  endfunction

  state_e                state_q, state_d;
  opcode_e               op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wr_sr_q, wr_sr_d;
  logic [DATA_WIDTH-1:0] out_sr_q, out_sr_d;
  logic                  miso_q, miso_d;
  logic                  err_q, err_d;
  logic [NUM_PBIT-1:0]   live_q, live_d;
  logic [NUM_PBIT-1:0]   snap_q, snap_d;
  logic [DATA_WIDTH-1:0] wt_data_q, wt_data_d;

  logic [DATA_WIDTH-1:0] mem [NUM_PBIT];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] addr_full;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  fall_pulse;

  pbit_clk_div #(.DIV_HALF(DIV_HALF)) u_clk_div (
    .clk        (clk),
    .rstn       (rstn),
    .clk_analog (clk_analog),
    .fall_pulse (fall_pulse)
  );

  assign addr_full = {addr_q[ADDR_WIDTH-2:0], MOSI};

  // SPI-side read: the start word while decoding the address, otherwise the next word of the burst.
  always_comb begin
    rd_addr = (state_q == ST_ADDR) ? addr_full : addr_inc(addr_q);
    rd_word = mem[rd_addr];
  end

  always_comb begin
    live_d    = fall_pulse ? bit_flips : live_q;
    wt_data_d = mem[wt_addr];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_sr_d   = wr_sr_q;
    out_sr_d  = out_sr_q;
    miso_d    = 1'b0;
    err_d     = err_q;
    snap_d    = snap_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = {wr_sr_q[DATA_WIDTH-2:0], MOSI};

    if (cs_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          op_d    = opcode_e'({op_q[OP_W-2:0], MOSI});
          state_d = ST_OPCODE;
        end
        ST_OPCODE: begin
          op_d    = opcode_e'({op_q[OP_W-2:0], MOSI});
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d = addr_full;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            cnt_d = '0;
            if (op_q == OP_NOP) begin
              state_d = ST_DRAIN;
            end else if (!in_range(addr_full)) begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              case (op_q)
                OP_WRITE: state_d = ST_WR_DATA;
                OP_READ_WT: begin
                  state_d  = ST_RD_WT;
                  miso_d   = rd_word[DATA_WIDTH-1];
                  out_sr_d = rd_word << 1;
                  cnt_d    = CNT_W'(1);
                end
                OP_READ_PB: begin
                  state_d = ST_RD_PB;
                  snap_d  = live_q;
                  miso_d  = live_q[addr_full];
                end
                default: state_d = ST_DRAIN;
              endcase
            end
          end
        end
        ST_WR_DATA: begin
          wr_sr_d = mem_wdata;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            mem_we = 1'b1;
            addr_d = addr_inc(addr_q);
            cnt_d  = '0;
          end
        end
        ST_RD_WT: begin
          // cnt_q counts bits of the current word already presented on MISO.
          if (cnt_q == CNT_W'(DATA_WIDTH)) begin
            miso_d   = rd_word[DATA_WIDTH-1];
            out_sr_d = rd_word << 1;
            cnt_d    = CNT_W'(1);
            addr_d   = addr_inc(addr_q);
          end else begin
            miso_d   = out_sr_q[DATA_WIDTH-1];
            out_sr_d = out_sr_q << 1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
        ST_RD_PB: begin
          addr_d = addr_inc(addr_q);
          miso_d = snap_q[addr_inc(addr_q)];
        end
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_sr_q   <= '0;
      out_sr_q  <= '0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
      live_q    <= '0;
      snap_q    <= '0;
      wt_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_sr_q   <= wr_sr_d;
      out_sr_q  <= out_sr_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
      live_q    <= live_d;
      snap_q    <= snap_d;
      wt_data_q <= wt_data_d;
    end
  end

  // SRAM contents survive reset; the analog port reads old data on a same-address write.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign MISO    = miso_q;
  assign wt_data = wt_data_q;
  assign err     = err_q;

endmodule
